// File: rtl/quant_cfu_pc.sv
// Per-channel requantization CFU: bias/multiplier/shift tables, 3-stage TFLite-style
// requantizer, int32 or packed-int8 responses over a valid/ready handshake.
module quant_cfu_pc #(
  parameter int unsigned INT32_SIZE = 32,
  parameter int unsigned BYTE_SIZE  = 8,
  parameter int unsigned NUM_CH     = 64,
  parameter int unsigned LANES      = INT32_SIZE / BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            cmd,
  input  logic [INT32_SIZE-1:0] inp0,
  input  logic [INT32_SIZE-1:0] inp1,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [INT32_SIZE-1:0] ret,
  output logic                  output_buffer_valid,
  input  logic                  rsp_ready
);
  localparam int unsigned AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned NW = AW + 1;
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {StIdle, StS1, StS2, StS3, StResp} state_e;
  state_e r_state, w_state_next;

  logic signed [31:0] r_bias  [NUM_CH];
  logic signed [31:0] r_mult  [NUM_CH];
  logic signed [31:0] r_shift [NUM_CH];

  logic [31:0]        r_ret, r_pack;
  logic [AW-1:0]      r_ptr;
  logic [NW-1:0]      r_nch;
  logic [LW-1:0]      r_lane;
  logic signed [31:0] r_act_min, r_act_max, r_offset;
  logic signed [31:0] r_acc, r_x, r_m, r_h;
  logic [4:0]         r_rs;
  logic               r_is_pack;

  logic               w_accept, w_quant, w_in_tab, w_cfg_err;
  logic [AW-1:0]      w_idx, w_ptr_next;
  logic [NW-1:0]      w_nch_new;
  logic [LW-1:0]      w_lane_next;
  logic signed [31:0] w_x0, w_x, w_neg, w_h, w_r, w_res;
  logic [4:0]         w_rs;
  logic signed [63:0] w_xe, w_me, w_p, w_sum, w_adj;
  logic               w_sat;
  logic [31:0]        w_mask, w_rem, w_thr, w_pack_new;
  logic signed [32:0] w_y, w_min33, w_max33, w_lo, w_cl;
  logic               w_unused;

  assign w_accept  = cmd_valid && (r_state == StIdle);
  assign w_quant   = (cmd == 7'd8) || (cmd == 7'd9);
  assign w_in_tab  = inp0 < NUM_CH;
  assign w_idx     = inp0[AW-1:0];
  assign w_nch_new = ((inp1 >= 32'd1) && (inp1 <= NUM_CH)) ? NW'(inp1) : NW'(NUM_CH);
  assign w_cfg_err = ((cmd == 7'd1 || cmd == 7'd2 || cmd == 7'd3) && !w_in_tab) ||
                     ((cmd == 7'd7) && (inp0 >= 32'(w_nch_new)));
  assign w_ptr_next  = (({1'b0, r_ptr} + NW'(1)) == r_nch) ? '0 : r_ptr + AW'(1);
  assign w_lane_next = (r_lane == LW'(LANES - 1)) ? '0 : r_lane + LW'(1);
  assign ret = r_ret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next        = r_state;
    cmd_ready           = 1'b0;
    output_buffer_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_next = w_quant ? StS1 : StResp;
      end
      StS1:   w_state_next = StS2;
      StS2:   w_state_next = StS3;
      StS3:   w_state_next = StResp;
      StResp: begin
        output_buffer_valid = 1'b1;
        if (rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    // S1: bias add and optional left shift; non-positive shift becomes a right-shift amount
    w_x0  = r_acc + r_bias[r_ptr];
    w_neg = -r_shift[r_ptr];
    w_x   = w_x0;
    w_rs  = 5'd0;
    if (r_shift[r_ptr] > 0)         w_x  = w_x0 << $unsigned(r_shift[r_ptr]);
    else if (r_shift[r_ptr] < -31)  w_rs = 5'd31;
    else                            w_rs = w_neg[4:0];
    // S2: saturating rounding doubling high multiply, truncating toward zero
    w_xe  = {{32{r_x[31]}}, r_x};
    w_me  = {{32{r_m[31]}}, r_m};
    w_p   = w_xe * w_me;
    w_sum = w_p + (w_p[63] ? -64'sd1073741823 : 64'sd1073741824);
    w_adj = w_sum + (w_sum[63] ? 64'sd2147483647 : 64'sd0);
    w_sat = (r_x == 32'h8000_0000) && (r_m == 32'h8000_0000);
    w_h   = w_sat ? 32'sh7FFF_FFFF : w_adj[62:31];
    // S3: round-half-away rounding shift, offset, clamp
    w_mask  = (32'd1 << r_rs) - 32'd1;
    w_rem   = r_h & w_mask;
    w_thr   = (w_mask >> 1) + {31'd0, r_h[31]};
    w_r     = (r_h >>> r_rs) + $signed({31'd0, (w_rem > w_thr)});
    w_y     = {w_r[31], w_r} + {r_offset[31], r_offset};
    w_min33 = {r_act_min[31], r_act_min};
    w_max33 = {r_act_max[31], r_act_max};
    w_lo    = (w_y < w_min33) ? w_min33 : w_y;
    w_cl    = (w_lo > w_max33) ? w_max33 : w_lo;
    w_res   = w_cl[31:0];
    w_pack_new = (r_lane == '0) ? 32'h0 : r_pack;
    for (int i = 0; i < int'(LANES); i++) begin
      if (r_lane == LW'(i)) w_pack_new[i*BYTE_SIZE +: BYTE_SIZE] = w_res[BYTE_SIZE-1:0];
    end
  end

  assign w_unused = ^{w_adj[63], w_adj[30:0], w_cl[32], w_neg[31:5]};

  // Tables behave as RAM: no reset, writes land on the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_tab) begin
      case (cmd)
        7'd1:    r_bias[w_idx]  <= inp1;
        7'd2:    r_mult[w_idx]  <= inp1;
        7'd3:    r_shift[w_idx] <= inp1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret     <= '0;
      r_pack    <= '0;
      r_ptr     <= '0;
      r_nch     <= NW'(NUM_CH);
      r_lane    <= '0;
      r_act_min <= -32'sd128;
      r_act_max <= 32'sd127;
      r_offset  <= '0;
      r_acc     <= '0;
      r_x       <= '0;
      r_m       <= '0;
      r_h       <= '0;
      r_rs      <= '0;
      r_is_pack <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc     <= inp1;
        r_is_pack <= (cmd == 7'd9);
        if (!w_quant) begin
          r_ret <= w_cfg_err ? 32'hFFFF_FFFF : 32'h0;
          case (cmd)
            7'd0: begin
              r_ptr  <= '0;
              r_lane <= '0;
              r_pack <= '0;
              r_nch  <= NW'(NUM_CH);
            end
            7'd4: r_act_min <= inp1;
            7'd5: r_act_max <= inp1;
            7'd6: r_offset  <= inp1;
            7'd7: if (!w_cfg_err) begin
              r_ptr  <= w_idx;
              r_nch  <= w_nch_new;
              r_lane <= '0;
              r_pack <= '0;
            end
            default: ;
          endcase
        end
      end
      if (r_state == StS1) begin
        r_x  <= w_x;
        r_m  <= r_mult[r_ptr];
        r_rs <= w_rs;
      end
      if (r_state == StS2) r_h <= w_h;
      if (r_state == StS3) begin
        r_ret <= r_is_pack ? w_pack_new : w_res;
        r_ptr <= w_ptr_next;
        if (r_is_pack) begin
          r_pack <= w_pack_new;
          r_lane <= w_lane_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_quant_cfu_pc.sv
// Randomized self-checking bench for quant_cfu_pc against an arithmetic reference model.
module tb_quant_cfu_pc;
  localparam int NUM_CH = 64;
  localparam int IMIN   = 32'sh8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  cmd = '0;
  logic [31:0] inp0 = '0, inp1 = '0;
  logic        cmd_valid = 1'b0, rsp_ready = 1'b1;
  logic        cmd_ready, output_buffer_valid;
  logic [31:0] ret;

  quant_cfu_pc #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .inp0(inp0), .inp1(inp1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .ret(ret),
    .output_buffer_valid(output_buffer_valid), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int m_bias[NUM_CH], m_mult[NUM_CH], m_shift[NUM_CH];
  int m_ptr, m_nch, m_lane, m_min, m_max, m_off;
  logic [31:0] m_pack;

  task automatic model_reset();
    m_ptr = 0; m_nch = NUM_CH; m_lane = 0; m_pack = '0;
    m_min = -128; m_max = 127; m_off = 0;
  endtask

  function automatic int requant(int acc, int ch);
    int x, sh, rs, h;
    longint p, n, d, q, rm, y;
    x = acc + m_bias[ch];
    sh = m_shift[ch];
    rs = 0;
    if (sh > 0) x = (sh >= 32) ? 0 : (x << sh);
    else rs = (sh < -31) ? 31 : -sh;
    p = longint'(x) * longint'(m_mult[ch]);
    if (x == IMIN && m_mult[ch] == IMIN) h = 32'sh7FFF_FFFF;
    else begin
      n = (p >= 0) ? (64'sd1 << 30) : (64'sd1 - (64'sd1 << 30));
      h = int'((p + n) / (64'sd1 << 31));
    end
    q = longint'(h);
    if (rs != 0) begin
      d = 64'sd1 << rs;
      q = longint'(h) / d;
      rm = longint'(h) - q * d;
      if (2 * ((rm < 0) ? -rm : rm) >= d) q = q + ((h < 0) ? -1 : 1);
    end
    y = q + longint'(m_off);
    if (y < longint'(m_min)) y = longint'(m_min);
    if (y > longint'(m_max)) y = longint'(m_max);
    return int'(y);
  endfunction

  function automatic logic [31:0] m_exec(input logic [6:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    int y, n;
    case (c)
      7'd0: begin m_ptr = 0; m_lane = 0; m_pack = '0; m_nch = NUM_CH; return 0; end
      7'd1, 7'd2, 7'd3: begin
        if (a >= NUM_CH) return 32'hFFFF_FFFF;
        if (c == 7'd1) m_bias[a] = b;
        else if (c == 7'd2) m_mult[a] = b;
        else m_shift[a] = b;
        return 0;
      end
      7'd4: begin m_min = b; return 0; end
      7'd5: begin m_max = b; return 0; end
      7'd6: begin m_off = b; return 0; end
      7'd7: begin
        n = (b >= 1 && b <= NUM_CH) ? int'(b) : NUM_CH;
        if (a >= n) return 32'hFFFF_FFFF;
        m_ptr = a; m_nch = n; m_lane = 0; m_pack = '0;
        return 0;
      end
      7'd8, 7'd9: begin
        y = requant(b, m_ptr);
        m_ptr = (m_ptr + 1 == m_nch) ? 0 : m_ptr + 1;
        if (c == 7'd8) return y;
        if (m_lane == 0) m_pack = '0;
        m_pack[m_lane*8 +: 8] = y[7:0];
        m_lane = (m_lane + 1) % 4;
        return m_pack;
      end
      default: return 0;
    endcase
  endfunction

  // Issue one command; lat counts edges from the accept edge (=1) until valid is seen.
  task automatic send(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] r, output int lat);
    @(negedge clk);
    cmd = c; inp0 = a; inp1 = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!output_buffer_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = ret;
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic op(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                    output logic [31:0] r);
    logic [31:0] exp;
    int lat;
    exp = m_exec(c, a, b);
    send(c, a, b, r, lat);
    chk($sformatf("ret_cmd%0d", c), r, exp);
    chk($sformatf("lat_cmd%0d", c), lat, (c == 7'd8 || c == 7'd9) ? 4 : 1);
  endtask

  task automatic rand_op();
    int sel;
    logic [6:0] c;
    logic [31:0] a, b, r;
    sel = $urandom_range(0, 99);
    a = 0;
    b = $urandom;
    if (sel < 25) c = 7'd8;
    else if (sel < 42) c = 7'd9;
    else if (sel < 57) begin
      c = 7'($urandom_range(1, 3));
      a = $urandom_range(0, NUM_CH + 3);
      if (c == 7'd3) b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 80) - 40);
      if (c == 7'd1 && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 2000) - 1000);
    end else if (sel < 64) begin
      c = 7'($urandom_range(4, 6));
      if (c == 7'd6) b = 32'($urandom_range(0, 200) - 100);
      else if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 255) - 128);
    end else if (sel < 72) begin
      c = 7'd7;
      a = $urandom_range(0, NUM_CH + 2);
      b = $urandom_range(0, NUM_CH + 3);
    end else if (sel < 75) c = 7'd0;
    else begin
      c = 7'($urandom_range(10, 127));
      a = $urandom;
    end
    op(c, a, b, r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, exp, acc;
    int lat;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valid", output_buffer_valid, 0);
    chk("rst_ret", ret, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int ch = 0; ch < NUM_CH; ch++) begin
      op(7'd1, ch, 0, r);
      op(7'd2, ch, 0, r);
      op(7'd3, ch, 0, r);
    end
    op(7'd8, 0, $urandom, r);
    chk("zero_tab", r, 0);

    op(7'd0, 0, 0, r);
    op(7'd1, 0, 28, r);
    op(7'd2, 0, 32'h4000_0000, r);
    op(7'd3, 0, 32'hFFFF_FFFF, r);
    op(7'd6, 0, -5, r);
    op(7'd8, 0, 100, r);
    chk("dir_27", r, 27);
    op(7'd0, 0, 0, r);
    op(7'd8, 0, 1000, r);
    chk("dir_clamp127", r, 127);

    op(7'd4, 0, 32'h8000_0000, r);
    op(7'd5, 0, 32'h7FFF_FFFF, r);
    op(7'd1, 0, 0, r);
    op(7'd2, 0, 32'h8000_0000, r);
    op(7'd3, 0, 0, r);
    op(7'd6, 0, 0, r);
    op(7'd0, 0, 0, r);
    op(7'd8, 0, 32'h8000_0000, r);
    chk("sat_max", r, 32'h7FFF_FFFF);

    op(7'd4, 0, -128, r);
    op(7'd5, 0, 127, r);
    for (int k = 0; k < 4; k++) begin
      op(7'd1, k, k + 1, r);
      op(7'd2, k, 32'h4000_0000, r);
      op(7'd3, k, 1, r);
    end
    op(7'd7, 0, 4, r);
    op(7'd9, 0, 0, r); chk("pack1", r, 32'h0000_0001);
    op(7'd9, 0, 0, r); chk("pack2", r, 32'h0000_0201);
    op(7'd9, 0, 0, r); chk("pack3", r, 32'h0003_0201);
    op(7'd9, 0, 0, r); chk("pack4", r, 32'h0403_0201);
    op(7'd9, 0, 0, r); chk("pack_wrap", r, 32'h0000_0001);

    op(7'd1, NUM_CH, 123, r);
    chk("err_bias_oob", r, 32'hFFFF_FFFF);
    op(7'd7, 5, 4, r);
    chk("err_ptr_oob", r, 32'hFFFF_FFFF);
    op(7'd7, 0, 4, r);
    op(7'd8, 0, 0, r);
    chk("tab_kept", r, 1);

    for (int i = 0; i < 300; i++) rand_op();

    // Response stall: output held, new commands refused.
    acc = $urandom;
    exp = m_exec(7'd8, 0, acc);
    rsp_ready = 1'b0;
    send(7'd8, 0, acc, r, lat);
    chk("stall_lat", lat, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd = 7'd4; inp1 = 32'd5; cmd_valid = 1'b1;
      @(posedge clk); #1;
      chk("stall_ret", ret, exp);
      chk("stall_ready", cmd_ready, 0);
      chk("stall_valid", output_buffer_valid, 1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid_low", output_buffer_valid, 0);
    chk("hs_ready", cmd_ready, 1);
    chk("hs_ret_kept", ret, exp);
    for (int i = 0; i < 10; i++) rand_op();

    // Reset while the request sits in S2.
    @(negedge clk);
    cmd = 7'd9; inp1 = $urandom; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", output_buffer_valid, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_valid", output_buffer_valid, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_no_rsp", output_buffer_valid, 0);
    for (int i = 0; i < 40; i++) rand_op();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
